// File: rtl/dds_phase_gen_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg
// Shared defaults for the multi-channel DDS phase generator: channel count,
// accumulator and ROM address widths, marker address, reset values of the
// frequency/phase words and the encoding of the shadow-register select.
// -----------------------------------------------------------------------------
package dds_pkg;

    localparam int DDS_NUM_CH = 2;
    localparam int DDS_ACC_W  = 32;
    localparam int DDS_ADDR_W = 12;

    localparam logic [DDS_ADDR_W-1:0] DDS_MARK      = 12'hC00;
    localparam logic [DDS_ACC_W-1:0]  DDS_FWORD_RST = 32'h0000_0000;
    localparam logic [DDS_ADDR_W-1:0] DDS_PWORD_RST = 12'd2048;

    // wr_sel encodings
    localparam logic SEL_FWORD = 1'b0;
    localparam logic SEL_PWORD = 1'b1;

    // Width of a channel index; a single channel still gets one bit.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dds_phase_ch.sv
// -----------------------------------------------------------------------------
// dds_phase_ch
// One DDS channel: phase accumulator, registered ROM address, carry-out flag
// and marker-crossing detector.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   en          advance the accumulator this cycle
//   sync_clear  zero the accumulator, reload the address with the phase word
//   fword       active frequency word (accumulator increment)
//   pword       active phase word (added to the address)
//   addr        registered ROM address
//   strobe      one-cycle pulse when the address crosses MARK
//   wrap        one-cycle pulse on accumulator carry-out
// -----------------------------------------------------------------------------
module dds_phase_ch
    import dds_pkg::*;
#(
    parameter int                ACC_W  = DDS_ACC_W,
    parameter int                ADDR_W = DDS_ADDR_W,
    parameter logic [ADDR_W-1:0] MARK   = ADDR_W'(DDS_MARK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync_clear,
    input  logic [ACC_W-1:0]  fword,
    input  logic [ADDR_W-1:0] pword,
    output logic [ADDR_W-1:0] addr,
    output logic              strobe,
    output logic              wrap
);

    logic [ACC_W-1:0]  acc;
    logic [ACC_W:0]    acc_sum;
    logic [ADDR_W-1:0] addr_nxt;
    logic [ADDR_W-1:0] rel_prev;
    logic [ADDR_W-1:0] rel_new;
    logic              crossed;

    // One extra bit keeps the carry-out of the modular add.
    assign acc_sum  = {1'b0, acc} + {1'b0, fword};

    // Address uses the accumulator value before this cycle's update.
    assign addr_nxt = acc[ACC_W-1 -: ADDR_W] + pword;

    // Distance past MARK, modulo the address space. When the address moves
    // forward through MARK this distance drops, even if MARK itself is
    // stepped over. The history is simply the current address register, so
    // it is reloaded whenever the address is (reset, sync_clear, advance).
    assign rel_prev = addr     - MARK;
    assign rel_new  = addr_nxt - MARK;
    assign crossed  = (rel_new < rel_prev);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            addr   <= '0;
            strobe <= 1'b0;
            wrap   <= 1'b0;
        end else if (sync_clear) begin
            // Coherent restart: all channels begin again from phase zero.
            acc    <= '0;
            addr   <= pword;
            strobe <= 1'b0;
            wrap   <= 1'b0;
        end else if (en) begin
            acc    <= acc_sum[ACC_W-1:0];
            addr   <= addr_nxt;
            strobe <= crossed;
            wrap   <= acc_sum[ACC_W];
        end else begin
            strobe <= 1'b0;
            wrap   <= 1'b0;
        end
    end

endmodule

// File: rtl/dds_phase_gen.sv
// -----------------------------------------------------------------------------
// dds_phase_gen
// Multi-channel DDS phase accumulator / sine ROM address generator.
// Holds the double-buffered frequency and phase words (shadow bank written
// by the host, active bank loaded on commit) and instantiates one
// dds_phase_ch per channel.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   en          advance all accumulators
//   sync_clear  zero all accumulators (coherent phase restart)
//   wr_en       write the shadow word selected by wr_ch / wr_sel
//   wr_ch       channel index of the write (out-of-range indices ignored)
//   wr_sel      SEL_FWORD or SEL_PWORD
//   wr_data     write data; phase words use the low ADDR_W bits
//   commit      copy every shadow word to its active word
//   addr_out    packed ROM addresses, channel c at [c*ADDR_W +: ADDR_W]
//   strobe      per-channel marker-crossing pulse
//   wrap        per-channel accumulator carry-out pulse
//   valid       addr_out reflects an advanced accumulator
// -----------------------------------------------------------------------------
module dds_phase_gen
    import dds_pkg::*;
#(
    parameter int                NUM_CH    = DDS_NUM_CH,
    parameter int                ACC_W     = DDS_ACC_W,
    parameter int                ADDR_W    = DDS_ADDR_W,
    parameter logic [ADDR_W-1:0] MARK      = ADDR_W'(DDS_MARK),
    parameter logic [ACC_W-1:0]  FWORD_RST = ACC_W'(DDS_FWORD_RST),
    parameter logic [ADDR_W-1:0] PWORD_RST = ADDR_W'(DDS_PWORD_RST),
    localparam int               CH_W      = ch_idx_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     sync_clear,
    input  logic                     wr_en,
    input  logic [CH_W-1:0]          wr_ch,
    input  logic                     wr_sel,
    input  logic [ACC_W-1:0]         wr_data,
    input  logic                     commit,
    output logic [NUM_CH*ADDR_W-1:0] addr_out,
    output logic [NUM_CH-1:0]        strobe,
    output logic [NUM_CH-1:0]        wrap,
    output logic                     valid
);

    logic [ACC_W-1:0]  fword_shd     [NUM_CH];
    logic [ACC_W-1:0]  fword_act     [NUM_CH];
    logic [ADDR_W-1:0] pword_shd     [NUM_CH];
    logic [ADDR_W-1:0] pword_act     [NUM_CH];
    logic [ACC_W-1:0]  fword_shd_nxt [NUM_CH];
    logic [ADDR_W-1:0] pword_shd_nxt [NUM_CH];

    // Shadow write decode. Comparing against every legal channel index means
    // an index of NUM_CH or above matches nothing and the write is dropped.
    always_comb begin
        fword_shd_nxt = fword_shd;
        pword_shd_nxt = pword_shd;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en && (wr_ch == CH_W'(c))) begin
                if (wr_sel == SEL_FWORD) begin
                    fword_shd_nxt[c] = wr_data;
                end else begin
                    pword_shd_nxt[c] = wr_data[ADDR_W-1:0];
                end
            end
        end
    end

    // Commit copies the post-write shadow value, so a write in the same
    // cycle as commit goes straight through to the active bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                fword_shd[c] <= FWORD_RST;
                fword_act[c] <= FWORD_RST;
                pword_shd[c] <= PWORD_RST;
                pword_act[c] <= PWORD_RST;
            end
        end else begin
            fword_shd <= fword_shd_nxt;
            pword_shd <= pword_shd_nxt;
            if (commit) begin
                fword_act <= fword_shd_nxt;
                pword_act <= pword_shd_nxt;
            end
        end
    end

    // Sticky once the first advance has reached the address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (en) begin
            valid <= 1'b1;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        dds_phase_ch #(
            .ACC_W  (ACC_W),
            .ADDR_W (ADDR_W),
            .MARK   (MARK)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .sync_clear (sync_clear),
            .fword      (fword_act[c]),
            .pword      (pword_act[c]),
            .addr       (addr_out[c*ADDR_W +: ADDR_W]),
            .strobe     (strobe[c]),
            .wrap       (wrap[c])
        );
    end

endmodule

// File: tb/tb_dds_phase_gen.sv
// -----------------------------------------------------------------------------
// tb_dds_phase_gen
// Self-checking bench for dds_phase_gen: a vector table, hand-written corner
// sequences and a randomized run, all compared every cycle against an
// arithmetic reference model of the channel behaviour.
// -----------------------------------------------------------------------------
module tb_dds_phase_gen;
    import dds_pkg::*;

    localparam int NCH   = 2;
    localparam int DW    = 12;
    localparam int MARKI = 'hC00;
    localparam longint unsigned TWO32 = 64'h1_0000_0000;

    logic            clk = 1'b0;
    logic            rst, en, sync_clear, wr_en, wr_sel, commit;
    logic [0:0]      wr_ch;
    logic [31:0]     wr_data;
    logic [NCH*DW-1:0] addr_out;
    logic [NCH-1:0]  strobe, wrap;
    logic            valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dds_phase_gen dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sync_clear (sync_clear),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .commit     (commit),
        .addr_out   (addr_out),
        .strobe     (strobe),
        .wrap       (wrap),
        .valid      (valid)
    );

    // ---------------- reference model (plain arithmetic) ----------------
    longint unsigned m_acc [NCH];
    longint unsigned m_fa  [NCH];
    longint unsigned m_fs  [NCH];
    int m_pa [NCH];
    int m_ps [NCH];
    int m_addr [NCH];
    int m_strobe [NCH];
    int m_wrap [NCH];
    int m_valid;

    function automatic int rel(input int a);
        return (a - MARKI + 4096) % 4096;
    endfunction

    task automatic model_step();
        longint unsigned s;
        int na;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_acc[c] = 0; m_fa[c] = 0; m_fs[c] = 0;
                m_pa[c] = 2048; m_ps[c] = 2048;
                m_addr[c] = 0; m_strobe[c] = 0; m_wrap[c] = 0;
            end
            m_valid = 0;
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            if (sync_clear) begin
                m_acc[c] = 0; m_addr[c] = m_pa[c];
                m_strobe[c] = 0; m_wrap[c] = 0;
            end else if (en) begin
                s  = m_acc[c] + m_fa[c];
                na = int'(((m_acc[c] / 64'd1048576) + longint'(m_pa[c])) % 64'd4096);
                m_strobe[c] = (rel(na) < rel(m_addr[c])) ? 1 : 0;
                m_wrap[c]   = (s >= TWO32) ? 1 : 0;
                m_acc[c]    = s % TWO32;
                m_addr[c]   = na;
            end else begin
                m_strobe[c] = 0; m_wrap[c] = 0;
            end
        end
        if (en) m_valid = 1;
        if (wr_en && (int'(wr_ch) < NCH)) begin
            if (wr_sel == SEL_FWORD) m_fs[wr_ch] = longint'(wr_data);
            else                     m_ps[wr_ch] = int'(wr_data % 4096);
        end
        if (commit) begin
            for (int c = 0; c < NCH; c++) begin
                m_fa[c] = m_fs[c];
                m_pa[c] = m_ps[c];
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] addr_of(input int c);
        return addr_out[c*DW +: DW];
    endfunction

    task automatic check_model();
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("model_addr%0d", c),   32'(addr_of(c)), 32'(m_addr[c]));
            chk($sformatf("model_strobe%0d", c), 32'(strobe[c]),  32'(m_strobe[c]));
            chk($sformatf("model_wrap%0d", c),   32'(wrap[c]),    32'(m_wrap[c]));
        end
        chk("model_valid", 32'(valid), 32'(m_valid));
    endtask

    // One clock: inputs are stable at the edge, model steps with the DUT,
    // outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic idle_inputs();
        rst = 0; sync_clear = 0; wr_en = 0; wr_ch = 0;
        wr_sel = 0; wr_data = 0; commit = 0;
    endtask

    task automatic apply_reset();
        idle_inputs(); en = 0; rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic write_word(input int ch, input logic sel, input logic [31:0] d, input logic cm);
        wr_en = 1; wr_ch = 1'(ch); wr_sel = sel; wr_data = d; commit = cm;
        tick();
        wr_en = 0; commit = 0; wr_data = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        r, e, sc, we;
        logic [0:0]  ch;
        logic        sel;
        logic [31:0] d;
        logic        cm;
        logic [11:0] a0, a1;
        logic [1:0]  s, w;
        logic        v;
    } vec_t;

    vec_t tbl [15];

    int first_s, second_s, s1cnt;
    logic [11:0] p0, p1;

    initial begin
        // r  e  sc we ch sel data           cm  a0      a1      s      w      v
        tbl[0]  = '{1,0,0,0,0,0,32'h0,        0, 12'h000, 12'h000, 2'b00, 2'b00, 0};
        tbl[1]  = '{0,0,0,1,0,0,32'h50000000, 0, 12'h000, 12'h000, 2'b00, 2'b00, 0};
        tbl[2]  = '{0,0,0,1,0,1,32'h0,        0, 12'h000, 12'h000, 2'b00, 2'b00, 0};
        tbl[3]  = '{0,0,0,1,1,0,32'h80000000, 0, 12'h000, 12'h000, 2'b00, 2'b00, 0};
        tbl[4]  = '{0,0,0,1,1,1,32'h100,      1, 12'h000, 12'h000, 2'b00, 2'b00, 0};
        tbl[5]  = '{0,1,0,0,0,0,32'h0,        0, 12'h000, 12'h100, 2'b00, 2'b00, 1};
        tbl[6]  = '{0,1,0,0,0,0,32'h0,        0, 12'h500, 12'h900, 2'b00, 2'b10, 1};
        tbl[7]  = '{0,1,0,0,0,0,32'h0,        0, 12'hA00, 12'h100, 2'b10, 2'b00, 1};
        tbl[8]  = '{0,1,0,0,0,0,32'h0,        0, 12'hF00, 12'h900, 2'b01, 2'b11, 1};
        tbl[9]  = '{0,0,0,0,0,0,32'h0,        0, 12'hF00, 12'h900, 2'b00, 2'b00, 1};
        tbl[10] = '{0,1,1,0,0,0,32'h0,        0, 12'h000, 12'h100, 2'b00, 2'b00, 1};
        tbl[11] = '{0,1,0,0,0,0,32'h0,        0, 12'h000, 12'h100, 2'b00, 2'b00, 1};
        tbl[12] = '{1,1,0,0,0,0,32'h0,        0, 12'h000, 12'h000, 2'b00, 2'b00, 0};
        tbl[13] = '{0,0,0,0,0,0,32'h0,        0, 12'h000, 12'h000, 2'b00, 2'b00, 0};
        tbl[14] = '{0,1,0,0,0,0,32'h0,        0, 12'h800, 12'h800, 2'b00, 2'b00, 1};

        idle_inputs(); en = 0;

        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].r; en = tbl[i].e; sync_clear = tbl[i].sc;
            wr_en = tbl[i].we; wr_ch = tbl[i].ch; wr_sel = tbl[i].sel;
            wr_data = tbl[i].d; commit = tbl[i].cm;
            tick();
            chk($sformatf("vec%0d_addr0", i),  32'(addr_of(0)), 32'(tbl[i].a0));
            chk($sformatf("vec%0d_addr1", i),  32'(addr_of(1)), 32'(tbl[i].a1));
            chk($sformatf("vec%0d_strobe", i), 32'(strobe),     32'(tbl[i].s));
            chk($sformatf("vec%0d_wrap", i),   32'(wrap),       32'(tbl[i].w));
            chk($sformatf("vec%0d_valid", i),  32'(valid),      32'(tbl[i].v));
        end
        idle_inputs(); en = 0;

        // ---- step of one address per cycle: strobe at 0xC00 then every 4096
        apply_reset();
        write_word(0, SEL_FWORD, 32'h00100000, 0);
        write_word(0, SEL_PWORD, 32'h0, 1);
        en = 1; first_s = -1; second_s = -1; s1cnt = 0;
        for (int k = 1; k <= 'hC01 + 4096 + 4; k++) begin
            tick();
            if (k <= 4) chk("t1_latency_addr0", 32'(addr_of(0)), 32'(k - 1));
            if (strobe[0]) begin
                if (first_s < 0) begin
                    first_s = k;
                    chk("t1_mark_addr0", 32'(addr_of(0)), 32'hC00);
                end else if (second_s < 0) begin
                    second_s = k;
                end
            end
            if (strobe[1]) s1cnt++;
        end
        chk("t1_first_strobe_cycle", 32'(first_s), 32'hC01);
        chk("t1_strobe_period", 32'(second_s - first_s), 32'd4096);
        chk("t1_zero_step_no_strobe", 32'(s1cnt), 32'd0);

        // ---- accumulator 0xFFFFFFFF + 1 wraps to zero
        apply_reset();
        write_word(0, SEL_FWORD, 32'hFFFFFFFF, 1);
        en = 1;
        write_word(0, SEL_FWORD, 32'h1, 1);
        chk("t3_no_wrap_first", 32'(wrap[0]), 32'd0);
        tick();
        chk("t3_wrap_at_carry", 32'(wrap[0]), 32'd1);
        chk("t3_addr_before_carry", 32'(addr_of(0)), 32'h7FF);
        tick();
        chk("t3_wrap_cleared", 32'(wrap[0]), 32'd0);
        chk("t3_acc_zero_addr", 32'(addr_of(0)), 32'h800);

        // ---- shadow write without commit, then commit, then write-through
        apply_reset();
        write_word(0, SEL_FWORD, 32'h00100000, 0);
        write_word(1, SEL_FWORD, 32'h00100000, 1);
        en = 1;
        tick(); tick(); tick();
        write_word(1, SEL_FWORD, 32'h00200000, 0);
        for (int k = 0; k < 10; k++) begin
            p0 = addr_of(0); p1 = addr_of(1);
            tick();
            chk("t4_uncommitted_step1", 32'((addr_of(1) - p1) & 12'hFFF), 32'd1);
        end
        commit = 1; tick(); commit = 0;
        p1 = addr_of(1); tick();
        chk("t4_step_before_effect", 32'((addr_of(1) - p1) & 12'hFFF), 32'd1);
        p0 = addr_of(0); p1 = addr_of(1); tick();
        chk("t4_committed_step2", 32'((addr_of(1) - p1) & 12'hFFF), 32'd2);
        chk("t4_ch0_unaffected", 32'((addr_of(0) - p0) & 12'hFFF), 32'd1);
        write_word(1, SEL_FWORD, 32'h00300000, 1);
        tick();
        p1 = addr_of(1); tick();
        chk("t4_write_through_step3", 32'((addr_of(1) - p1) & 12'hFFF), 32'd3);

        // ---- mid-run sync_clear with distinct phase words
        write_word(0, SEL_PWORD, 32'h123, 0);
        write_word(1, SEL_PWORD, 32'h456, 1);
        tick(); tick();
        sync_clear = 1; tick(); sync_clear = 0;
        chk("t5_clear_addr0", 32'(addr_of(0)), 32'h123);
        chk("t5_clear_addr1", 32'(addr_of(1)), 32'h456);
        chk("t5_clear_strobe", 32'(strobe), 32'd0);
        chk("t5_clear_wrap", 32'(wrap), 32'd0);
        tick(); tick();
        chk("t5_aligned_addr0", 32'(addr_of(0)), 32'h124);
        chk("t5_aligned_addr1", 32'(addr_of(1)), 32'h459);

        // ---- mid-run reset
        rst = 1; tick(); rst = 0;
        chk("t6_rst_addr", 32'(addr_out), 32'd0);
        chk("t6_rst_valid", 32'(valid), 32'd0);
        tick();
        chk("t6_first_addr0", 32'(addr_of(0)), 32'h800);

        // ---- randomized run against the model
        for (int k = 0; k < 2000; k++) begin
            rst        = ($urandom_range(199) == 0);
            sync_clear = ($urandom_range(49) == 0);
            en         = ($urandom_range(3) != 0);
            wr_en      = ($urandom_range(3) == 0);
            wr_ch      = 1'($urandom_range(1));
            wr_sel     = 1'($urandom_range(1));
            wr_data    = ($urandom_range(1) == 0) ? $urandom : ($urandom & 32'h00FF_FFFF);
            commit     = ($urandom_range(15) == 0);
            tick();
        end
        idle_inputs(); en = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
